alu_result_pipe: RTL and testbench

ALU_RESULT_PIPE -- requirements
Module: alu_result_pipe

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_result_sel.sv | 81 ++++++++
 rtl/alu_result_pipe.sv | 164 ++++++++++++++++
 tb/tb_alu_result_pipe.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared op-code encodings, flag bit positions and occupancy states for the ALU result pipe.
package alu_pkg;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_ADD   = 3'd1;
    localparam logic [2:0] OP_SUB   = 3'd2;
    localparam logic [2:0] OP_AND   = 3'd3;
    localparam logic [2:0] OP_OR    = 3'd4;
    localparam logic [2:0] OP_XOR   = 3'd5;
    localparam logic [2:0] OP_SLT   = 3'd6;
    localparam logic [2:0] OP_SHIFT = 3'd7;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StFull
    } occ_e;

    // Ops whose retire overwrites all four architectural flags.
    function automatic logic writes_cv(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT) || (op == OP_SHIFT);
    endfunction

    // Ops whose retire updates N and Z; only NOP leaves the flags untouched.
    function automatic logic writes_nz(input logic [2:0] op);
        return (op != OP_NOP);
    endfunction

endpackage

// File: rtl/alu_result_sel.sv
// Combinational result multiplexer and {N,Z,C,V} flag generation for one ALU operation.
module alu_result_sel
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter bit          SLT_OVF_FIX = 1'b1
) (
    input  logic [2:0]       control,
    input  logic [WIDTH-1:0] adder_result,
    input  logic [WIDTH-1:0] and_result,
    input  logic [WIDTH-1:0] or_result,
    input  logic [WIDTH-1:0] xor_result,
    input  logic [WIDTH-1:0] shift_result,
    input  logic             adder_c,
    input  logic             adder_v,
    input  logic             shift_c,
    input  logic             shift_v,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    logic lt;
    logic carry;
    logic ovf;

    // Signed less-than: the sign bit alone is wrong when the subtraction overflowed.
    always_comb begin
        if (SLT_OVF_FIX) begin
            lt = adder_result[WIDTH-1] ^ adder_v;
        end else begin
            lt = adder_result[WIDTH-1];
        end
    end

    always_comb begin
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (control)
            OP_NOP: begin
                result = '0;
            end
            OP_ADD, OP_SUB: begin
                result = adder_result;
                carry  = adder_c;
                ovf    = adder_v;
            end
            OP_AND: begin
                result = and_result;
            end
            OP_OR: begin
                result = or_result;
            end
            OP_XOR: begin
                result = xor_result;
            end
            OP_SLT: begin
                result = {{(WIDTH-1){1'b0}}, lt};
                carry  = adder_c;
                ovf    = adder_v;
            end
            OP_SHIFT: begin
                result = shift_result;
                carry  = shift_c;
                ovf    = shift_v;
            end
            default: begin
                result = '0;
            end
        endcase
    end

    always_comb begin
        flags         = 4'b0000;
        flags[FLAG_N] = result[WIDTH-1];
        flags[FLAG_Z] = (result == '0);
        flags[FLAG_C] = carry;
        flags[FLAG_V] = ovf;
    end

endmodule

// File: rtl/alu_result_pipe.sv
// Two-entry skid-buffered ALU result stage with architectural flag register and sticky overflow.
module alu_result_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter bit          SLT_OVF_FIX = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       control,
    input  logic [WIDTH-1:0] adder_result,
    input  logic [WIDTH-1:0] and_result,
    input  logic [WIDTH-1:0] or_result,
    input  logic [WIDTH-1:0] xor_result,
    input  logic [WIDTH-1:0] shift_result,
    input  logic             adder_c,
    input  logic             adder_v,
    input  logic             shift_c,
    input  logic             shift_v,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] bus_out,
    output logic [3:0]       out_flags,
    output logic [3:0]       flags_q,
    output logic             sticky_v,
    input  logic             clr_sticky
);

    logic [WIDTH-1:0] new_result;
    logic [3:0]       new_flags;

    occ_e             state_q, state_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [3:0]       out_flags_q, out_flags_d;
    logic [2:0]       out_op_q, out_op_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic [3:0]       skid_flags_q, skid_flags_d;
    logic [2:0]       skid_op_q, skid_op_d;
    logic [3:0]       arch_flags_q, arch_flags_d;
    logic             sticky_q, sticky_d;

    logic accept;
    logic take;

    alu_result_sel #(
        .WIDTH       (WIDTH),
        .SLT_OVF_FIX (SLT_OVF_FIX)
    ) u_sel (
        .control      (control),
        .adder_result (adder_result),
        .and_result   (and_result),
        .or_result    (or_result),
        .xor_result   (xor_result),
        .shift_result (shift_result),
        .adder_c      (adder_c),
        .adder_v      (adder_v),
        .shift_c      (shift_c),
        .shift_v      (shift_v),
        .result       (new_result),
        .flags        (new_flags)
    );

    // in_ready decodes the registered state only, so out_ready never reaches it.
    assign in_ready  = (state_q != StFull);
    assign out_valid = (state_q != StEmpty);
    assign bus_out   = out_data_q;
    assign out_flags = out_flags_q;
    assign flags_q   = arch_flags_q;
    assign sticky_v  = sticky_q;

    assign accept = in_valid && in_ready;
    assign take   = out_valid && out_ready;

    always_comb begin
        state_d      = state_q;
        out_data_d   = out_data_q;
        out_flags_d  = out_flags_q;
        out_op_d     = out_op_q;
        skid_data_d  = skid_data_q;
        skid_flags_d = skid_flags_q;
        skid_op_d    = skid_op_q;
        case (state_q)
            StEmpty: begin
                if (accept) begin
                    state_d     = StOne;
                    out_data_d  = new_result;
                    out_flags_d = new_flags;
                    out_op_d    = control;
                end
            end
            StOne: begin
                if (accept && !take) begin
                    state_d      = StFull;
                    skid_data_d  = new_result;
                    skid_flags_d = new_flags;
                    skid_op_d    = control;
                end else if (accept && take) begin
                    out_data_d  = new_result;
                    out_flags_d = new_flags;
                    out_op_d    = control;
                end else if (take) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (take) begin
                    state_d     = StOne;
                    out_data_d  = skid_data_q;
                    out_flags_d = skid_flags_q;
                    out_op_d    = skid_op_q;
                end
            end
            default: begin
                state_d = StEmpty;
            end
        endcase
    end

    // Architectural flags and sticky overflow only move when a result retires.
    always_comb begin
        arch_flags_d = arch_flags_q;
        sticky_d     = sticky_q;
        if (take) begin
            if (writes_cv(out_op_q)) begin
                arch_flags_d = out_flags_q;
            end else if (writes_nz(out_op_q)) begin
                arch_flags_d[FLAG_N] = out_flags_q[FLAG_N];
                arch_flags_d[FLAG_Z] = out_flags_q[FLAG_Z];
            end
        end
        if (take && out_flags_q[FLAG_V]) begin
            sticky_d = 1'b1;
        end else if (clr_sticky) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StEmpty;
            out_data_q   <= '0;
            out_flags_q  <= 4'b0000;
            out_op_q     <= OP_NOP;
            skid_data_q  <= '0;
            skid_flags_q <= 4'b0000;
            skid_op_q    <= OP_NOP;
            arch_flags_q <= 4'b0000;
            sticky_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_data_q   <= out_data_d;
            out_flags_q  <= out_flags_d;
            out_op_q     <= out_op_d;
            skid_data_q  <= skid_data_d;
            skid_flags_q <= skid_flags_d;
            skid_op_q    <= skid_op_d;
            arch_flags_q <= arch_flags_d;
            sticky_q     <= sticky_d;
        end
    end

endmodule

// File: tb/tb_alu_result_pipe.sv
// Directed bench for alu_result_pipe; a second instance covers the sign-bit-only SLT variant.
module tb_alu_result_pipe;
    import alu_pkg::*;

    localparam int unsigned W = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [2:0]   control;
    logic [W-1:0] adder_result, and_result, or_result, xor_result, shift_result;
    logic         adder_c, adder_v, shift_c, shift_v;
    logic         out_ready;
    logic         clr_sticky;

    logic         in_ready, out_valid, sticky_v;
    logic [W-1:0] bus_out;
    logic [3:0]   out_flags, flags_q;

    logic         in_ready0, out_valid0, sticky_v0;
    logic [W-1:0] bus_out0;
    logic [3:0]   out_flags0, flags_q0;

    int n_cmp  = 0;
    int n_fail = 0;

    alu_result_pipe #(.WIDTH(W), .SLT_OVF_FIX(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .control(control), .adder_result(adder_result), .and_result(and_result),
        .or_result(or_result), .xor_result(xor_result), .shift_result(shift_result),
        .adder_c(adder_c), .adder_v(adder_v), .shift_c(shift_c), .shift_v(shift_v),
        .out_valid(out_valid), .out_ready(out_ready), .bus_out(bus_out),
        .out_flags(out_flags), .flags_q(flags_q), .sticky_v(sticky_v),
        .clr_sticky(clr_sticky)
    );

    alu_result_pipe #(.WIDTH(W), .SLT_OVF_FIX(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .control(control), .adder_result(adder_result), .and_result(and_result),
        .or_result(or_result), .xor_result(xor_result), .shift_result(shift_result),
        .adder_c(adder_c), .adder_v(adder_v), .shift_c(shift_c), .shift_v(shift_v),
        .out_valid(out_valid0), .out_ready(out_ready), .bus_out(bus_out0),
        .out_flags(out_flags0), .flags_q(flags_q0), .sticky_v(sticky_v0),
        .clr_sticky(clr_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid     = 1'b0;
        control      = OP_NOP;
        adder_result = '0;
        and_result   = '0;
        or_result    = '0;
        xor_result   = '0;
        shift_result = '0;
        adder_c      = 1'b0;
        adder_v      = 1'b0;
        shift_c      = 1'b0;
        shift_v      = 1'b0;
    endtask

    initial begin
        idle_inputs();
        out_ready  = 1'b1;
        clr_sticky = 1'b0;
        rst_n      = 1'b0;
        tick();
        tick();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_flags_q", {28'd0, flags_q}, 32'd0);
        check("rst_sticky", {31'd0, sticky_v}, 32'd0);
        check("rst_bus_out", bus_out, 32'd0);
        check("rst_out_flags", {28'd0, out_flags}, 32'd0);
        rst_n = 1'b1;

        // ADD giving zero with carry: accepted on first edge after reset release
        in_valid = 1'b1; control = OP_ADD; adder_result = 32'h0; adder_c = 1'b1;
        tick();
        check("add0_valid", {31'd0, out_valid}, 32'd1);
        check("add0_bus", bus_out, 32'd0);
        check("add0_oflags", {28'd0, out_flags}, 32'h6);
        check("add0_flags_before_retire", {28'd0, flags_q}, 32'd0);
        idle_inputs();
        tick();
        check("add0_flags_q", {28'd0, flags_q}, 32'h6);
        check("add0_drained", {31'd0, out_valid}, 32'd0);

        // SLT with overflowed subtraction, both variants
        in_valid = 1'b1; control = OP_SLT; adder_result = 32'h8000_0000; adder_v = 1'b1;
        tick();
        check("slt_fix_bus", bus_out, 32'd0);
        check("slt_fix_oflags", {28'd0, out_flags}, 32'h5);
        check("slt_nofix_bus", bus_out0, 32'd1);
        check("slt_nofix_oflags", {28'd0, out_flags0}, 32'h1);
        idle_inputs();
        tick();
        check("slt_flags_q", {28'd0, flags_q}, 32'h5);
        check("slt_sticky", {31'd0, sticky_v}, 32'd1);
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        check("slt_sticky_clr", {31'd0, sticky_v}, 32'd0);

        // SUB sets C,V; XOR zero keeps them; NOP leaves flags alone
        in_valid = 1'b1; control = OP_SUB; adder_result = 32'd5; adder_c = 1'b1; adder_v = 1'b1;
        tick();
        check("sub_bus", bus_out, 32'd5);
        check("sub_oflags", {28'd0, out_flags}, 32'h3);
        idle_inputs();
        in_valid = 1'b1; control = OP_XOR; xor_result = 32'h0;
        tick();
        check("sub_flags_q", {28'd0, flags_q}, 32'h3);
        check("xor_bus", bus_out, 32'd0);
        check("xor_oflags", {28'd0, out_flags}, 32'h4);
        idle_inputs();
        in_valid = 1'b1; control = OP_NOP;
        tick();
        check("xor_flags_q", {28'd0, flags_q}, 32'h7);
        check("nop_oflags", {28'd0, out_flags}, 32'h4);
        idle_inputs();
        tick();
        check("nop_flags_q", {28'd0, flags_q}, 32'h7);

        // sticky: set beats same-cycle clear, then clear alone works
        clr_sticky = 1'b1;
        tick();
        check("sticky_pre_clr", {31'd0, sticky_v}, 32'd0);
        in_valid = 1'b1; control = OP_ADD; adder_result = 32'h8000_0000; adder_v = 1'b1;
        tick();
        idle_inputs();
        tick();
        check("sticky_set_wins", {31'd0, sticky_v}, 32'd1);
        tick();
        check("sticky_clr_next", {31'd0, sticky_v}, 32'd0);
        clr_sticky = 1'b0;
        check("addv_flags_q", {28'd0, flags_q}, 32'h9);

        // backpressure: three ops, third stalls until output drains
        out_ready = 1'b0;
        in_valid = 1'b1; control = OP_ADD; adder_result = 32'd5;
        tick();
        check("bp_in_ready_1", {31'd0, in_ready}, 32'd1);
        check("bp_bus_1", bus_out, 32'd5);
        idle_inputs();
        in_valid = 1'b1; control = OP_AND; and_result = 32'd6;
        tick();
        check("bp_in_ready_2", {31'd0, in_ready}, 32'd0);
        check("bp_hold_a", bus_out, 32'd5);
        idle_inputs();
        in_valid = 1'b1; control = OP_OR; or_result = 32'd7;
        tick();
        check("bp_stall_ready", {31'd0, in_ready}, 32'd0);
        check("bp_hold_b", bus_out, 32'd5);
        check("bp_hold_flags", {28'd0, out_flags}, 32'h0);
        out_ready = 1'b1;
        tick();
        check("bp_bus_2", bus_out, 32'd6);
        check("bp_flags_after_add", {28'd0, flags_q}, 32'h0);
        check("bp_in_ready_reopen", {31'd0, in_ready}, 32'd1);
        tick();
        check("bp_bus_3", bus_out, 32'd7);
        check("bp_valid_3", {31'd0, out_valid}, 32'd1);
        idle_inputs();
        tick();
        check("bp_drained", {31'd0, out_valid}, 32'd0);

        // SHIFT sets all four flags
        in_valid = 1'b1; control = OP_SHIFT; shift_result = 32'hFFFF_FFFF; shift_c = 1'b1;
        tick();
        check("shift_oflags", {28'd0, out_flags}, 32'hA);
        idle_inputs();
        tick();
        check("shift_flags_q", {28'd0, flags_q}, 32'hA);

        // fill both entries, then reset asynchronously mid-cycle
        out_ready = 1'b0;
        in_valid = 1'b1; control = OP_ADD; adder_result = 32'h8000_0001; adder_c = 1'b1;
        adder_v = 1'b1;
        tick();
        control = OP_SUB; adder_result = 32'd0;
        tick();
        idle_inputs();
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_flags_q", {28'd0, flags_q}, 32'd0);
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        check("arst_bus_out", bus_out, 32'd0);
        out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_valid", {31'd0, out_valid}, 32'd0);
        check("post_rst_flags_q", {28'd0, flags_q}, 32'd0);
        check("post_rst_sticky", {31'd0, sticky_v}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
